// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-in / serial-out shifter with a valid/ready
// load handshake and gapless back-to-back frames.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit per frame.
module piso_shift_register #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             final_cyc;
    logic             accept;
    logic             head_bit;

    // Last data bit of the frame is on the line
    assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

`ifdef PISO_PARITY_EN
    logic par_bit;
    assign final_cyc = (state == PARITY);
`else
    assign final_cyc = last_bit;
`endif

    // Ready in idle and in the final frame cycle so frames can abut; never in reset
    assign load_ready = !rst && ((state == IDLE) || final_cyc);
    assign accept     = load_valid && load_ready;

    // Bit currently at the output end of the shift register
    assign head_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last_bit) begin
                    if (accept) state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
                    else        state_nxt = PARITY;
`else
                    else        state_nxt = IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_nxt = accept ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, otherwise shift one bit per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= data_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            cnt   <= last_bit ? '0 : cnt + 1'b1;
        end
    end

`ifdef PISO_PARITY_EN
    // Parity is taken from the word as captured, not from the shifting copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         par_bit <= 1'b0;
        else if (accept) par_bit <= ^data_in;
    end
`endif

    // Outputs decoded from state and registers only
    always_comb begin
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            SHIFT: begin
                serial_out   = head_bit;
                serial_valid = 1'b1;
                busy         = 1'b1;
                done         = final_cyc;
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                serial_out   = par_bit;
                serial_valid = 1'b1;
                busy         = 1'b1;
                done         = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: one MSB-first and one LSB-first instance
// share the same stimulus; expected bits go into per-instance queues on each
// accepted load and are popped as the serial stream appears.
module tb_piso_shift_register;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = 8 + (PAR ? 1 : 0);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;
    logic       load_ready_m, serial_out_m, serial_valid_m, busy_m, done_m;
    logic       load_ready_l, serial_out_l, serial_valid_l, busy_l, done_l;

    always #5 clk = ~clk;

    piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready_m), .serial_out(serial_out_m),
        .serial_valid(serial_valid_m), .busy(busy_m), .done(done_m)
    );

    piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready_l), .serial_out(serial_out_l),
        .serial_valid(serial_valid_l), .busy(busy_l), .done(done_l)
    );

    typedef struct packed { logic b; logic d; } exp_t;
    typedef struct {
        logic [7:0] data;
        logic [7:0] msb_seq;  // transmission order, first bit at [7]
        logic [7:0] lsb_seq;
        logic       par;
    } vec_t;

    vec_t vecs[8];
    exp_t qm[$];
    exp_t ql[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input vec_t v);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.d = (i == 7) && !PAR;
            e.b = v.msb_seq[7-i]; qm.push_back(e);
            e.b = v.lsb_seq[7-i]; ql.push_back(e);
        end
        if (PAR) begin
            e.b = v.par; e.d = 1'b1;
            qm.push_back(e);
            ql.push_back(e);
        end
    endtask

    // Wait for ready, present one word for a single cycle
    task automatic send(input vec_t v);
        int n = 0;
        while (!load_ready_m && n < 40) begin step(); n++; end
        chk("send_ready_wait", load_ready_m, 1'b1);
        load_valid = 1'b1;
        data_in    = v.data;
        push_frame(v);
        step();
        load_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((qm.size() != 0 || ql.size() != 0) && n < 60) begin step(); n++; end
        chk("drain_m", qm.size() == 0, 1'b1);
        chk("drain_l", ql.size() == 0, 1'b1);
        step();
    endtask

    // Negedge monitor: a non-empty queue means the instance must be streaming
    task automatic mon();
        exp_t e;
        if (rst) begin
            chk("rst_valid_m", serial_valid_m, 1'b0);
            chk("rst_busy_m", busy_m, 1'b0);
            chk("rst_out_m", serial_out_m, 1'b0);
            chk("rst_done_m", done_m, 1'b0);
            chk("rst_ready_m", load_ready_m, 1'b0);
            chk("rst_valid_l", serial_valid_l, 1'b0);
            chk("rst_ready_l", load_ready_l, 1'b0);
        end else begin
            chk("valid_m", serial_valid_m, qm.size() != 0);
            chk("busy_m", busy_m, qm.size() != 0);
            if (qm.size() != 0) begin
                e = qm.pop_front();
                chk("bit_m", serial_out_m, e.b);
                chk("done_m", done_m, e.d);
            end else begin
                chk("idle_out_m", serial_out_m, 1'b0);
                chk("idle_done_m", done_m, 1'b0);
            end
            chk("valid_l", serial_valid_l, ql.size() != 0);
            chk("busy_l", busy_l, ql.size() != 0);
            if (ql.size() != 0) begin
                e = ql.pop_front();
                chk("bit_l", serial_out_l, e.b);
                chk("done_l", done_l, e.d);
            end else begin
                chk("idle_out_l", serial_out_l, 1'b0);
                chk("idle_done_l", done_l, 1'b0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hB3, 8'b10110011, 8'b11001101, 1'b1};
        vecs[1] = '{8'h03, 8'b00000011, 8'b11000000, 1'b0};
        vecs[2] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
        vecs[3] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
        vecs[4] = '{8'hFF, 8'b11111111, 8'b11111111, 1'b0};
        vecs[5] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
        vecs[6] = '{8'h80, 8'b10000000, 8'b00000001, 1'b1};
        vecs[7] = '{8'h6E, 8'b01101110, 8'b01110110, 1'b1};

        fork
            forever begin @(negedge clk); mon(); end
        join_none

        // Reset held for a few cycles, then ready on the first cycle after release
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("post_rst_ready_m", load_ready_m, 1'b1);
        chk("post_rst_ready_l", load_ready_l, 1'b1);

        // Table: one isolated frame per vector
        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
            drain();
        end

        // Streaming: valid held high, second word presented on the final cycle
        chk("stream_ready_c0", load_ready_m, 1'b1);
        load_valid = 1'b1;
        data_in    = vecs[2].data;
        push_frame(vecs[2]);
        for (int c = 1; c <= 2 * FL; c++) begin
            step();
            chk("stream_ready_m", load_ready_m, (c == FL) || (c == 2 * FL));
            chk("stream_ready_l", load_ready_l, (c == FL) || (c == 2 * FL));
            chk("stream_nogap", serial_valid_m, 1'b1);
            if (c == FL) begin
                data_in = vecs[3].data;
                push_frame(vecs[3]);
            end else begin
                data_in = 8'($urandom);
            end
            if (c == 2 * FL) load_valid = 1'b0;
        end
        step();
        chk("stream_end_idle", serial_valid_m, 1'b0);
        drain();

        // Load pulse while busy (not final cycle) is ignored
        send(vecs[0]);
        repeat (2) step();
        chk("busy_not_ready", load_ready_m, 1'b0);
        load_valid = 1'b1;
        data_in    = 8'h00;
        step();
        load_valid = 1'b0;
        drain();
        repeat (4) step();

        // Reset during the 4th bit of 0xFF aborts the frame at once
        send(vecs[4]);
        repeat (3) step();
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", serial_valid_m, 1'b0);
        chk("abort_busy", busy_m, 1'b0);
        chk("abort_out", serial_out_m, 1'b0);
        chk("abort_ready", load_ready_m, 1'b0);
        chk("abort_valid_l", serial_valid_l, 1'b0);
        qm.delete();
        ql.delete();
        step();
        rst = 1'b0;
        step();
        chk("abort_rel_ready", load_ready_m, 1'b1);
        chk("abort_rel_valid", serial_valid_m, 1'b0);
        repeat (12) step();

        // Parity frame after abort
        send(vecs[1]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_register.md
PISO_SHIFT_REGISTER -- requirements
Module: piso_shift_register

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is shifted out first, 0 = bit 0 first.
REQ-003 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port data_in, input, WIDTH: parallel word to serialize; sampled only on an accepted load.
REQ-006 Port load_valid, input, 1: data_in holds a word to send.
REQ-007 Port load_ready, output, 1: block can accept a word this cycle.
REQ-008 Port serial_out, output, 1: serial bit stream, one bit per clock.
REQ-009 Port serial_valid, output, 1: serial_out carries a frame bit this cycle.
REQ-010 Port busy, output, 1: a frame is in progress.
REQ-011 Port done, output, 1: one-cycle pulse marking the final bit of a frame.

Function
REQ-012 Accept: a load SHALL occur on a rising edge where load_valid and load_ready are both 1; data_in is captured into the shift register and the bit counter is cleared to 0.
REQ-013 States SHALL be IDLE and SHIFT, plus PARITY when REQ-026 applies.
REQ-014 IDLE -> SHIFT on accept; otherwise the block stays in IDLE.
REQ-015 SHIFT: the block SHALL hold for exactly WIDTH cycles, presenting one bit per cycle in MSB_FIRST order, with serial_valid = 1 and busy = 1.
REQ-016 SHIFT exit (counter = WIDTH-1): an accept on that edge SHALL re-enter SHIFT with the new word; otherwise the block goes to IDLE (or to PARITY when REQ-026 applies).
REQ-017 Latency: the first bit of an accepted word SHALL appear on serial_out in the cycle immediately after the accept edge.
REQ-018 load_ready SHALL be 1 in IDLE and in the final frame cycle, and 0 in all other cycles, giving gapless back-to-back frames.
REQ-019 done SHALL be 1 only during the final frame cycle (last data bit, or the parity bit when REQ-026 applies).
REQ-020 In IDLE: serial_out = 0, serial_valid = 0, busy = 0, done = 0.
REQ-021 serial_out, serial_valid, busy and done SHALL be driven from registers or from state only, with no combinational path from any input.
REQ-022 load_valid held high across frames SHALL cause continuous streaming; data_in changes outside accept edges SHALL have no effect.

Reset
REQ-023 While rst = 1: state = IDLE, shift register = 0, counter = 0, serial_out = 0, serial_valid = 0, busy = 0, done = 0, load_ready = 0.
REQ-024 rst asserted mid-frame SHALL abort the frame immediately (asynchronously); no remaining bits are sent after release.
REQ-025 load_ready SHALL become 1 in the first cycle after rst deasserts.

Configuration
REQ-026 Macro PISO_PARITY_EN defined: after the WIDTH data bits, one PARITY cycle SHALL output the even parity bit (XOR of the captured word) with serial_valid = 1 and busy = 1. load_ready and done apply to this cycle, and an accept in it behaves as in REQ-016.
REQ-027 Macro PISO_PARITY_EN undefined: there is no PARITY state and each frame is exactly WIDTH cycles.

Verification
REQ-028 Reset then accept 0xB3 (WIDTH = 8, MSB_FIRST = 1) -> serial_out 1,0,1,1,0,0,1,1 on the 8 following cycles, serial_valid high for exactly 8 cycles, done high on the 8th only.
REQ-029 MSB_FIRST = 0, accept 0xB3 -> serial_out 1,1,0,0,1,1,0,1.
REQ-030 load_valid held high with 0xA5 then 0x3C presented on the final cycle -> 16 contiguous valid bits 10100101 00111100, no idle gap, and load_ready high only in cycles 0, 8 and 16.
REQ-031 rst pulsed during the 4th bit of 0xFF -> serial_valid and busy drop immediately, serial_out = 0, and load_ready = 1 one cycle after release.
REQ-032 load_valid pulsed while busy and not in the final cycle, with data 0x00 -> ignored, and the current frame completes unchanged.
REQ-033 PISO_PARITY_EN defined, accept 0xB3 -> 8 data bits then parity bit 1, 9 valid cycles, done on the 9th; accept 0x03 -> parity bit 0.
